// File: rtl/golden_nonce_queue_if.sv
// golden_nonce_queue_if
//   Groups the enqueue side (push/push_word) and the serial_transmit
//   handshake (tx_word/tx_send/tx_busy) of golden_nonce_queue.
//   slave  : the queue's view (consumes push, drives tx_word/tx_send).
//   master : the surrounding logic's view (hasher + serial_transmit).
// Signals:
//   push       one-cycle strobe, push_word is a golden nonce
//   push_word  nonce to enqueue
//   tx_word    word presented to serial_transmit
//   tx_send    one-cycle send request
//   tx_busy    serial_transmit busy
interface golden_nonce_queue_if #(
  parameter int WIDTH = 32
);
  logic             push;
  logic [WIDTH-1:0] push_word;
  logic [WIDTH-1:0] tx_word;
  logic             tx_send;
  logic             tx_busy;

  modport master (
    output push, push_word, tx_busy,
    input  tx_word, tx_send
  );

  modport slave (
    input  push, push_word, tx_busy,
    output tx_word, tx_send
  );
endinterface

// File: rtl/golden_nonce_queue.sv
// golden_nonce_queue
//   Buffers golden nonces from the hashing control unit and hands them to
//   serial_transmit one at a time over its send/busy handshake. Nonces that
//   arrive while the UART is busy are queued in order; pushes into a full
//   queue are dropped, flagged (sticky overflow) and counted (saturating).
// Ports:
//   hash_clk    clock, all logic on posedge
//   reset_in    asynchronous active-low reset
//   flush       synchronous clear of queue, counters and handshake FSM
//   nq          golden_nonce_queue_if.slave (push side + UART handshake)
//   count       entries held, including the word in flight
//   empty/full  registered count==0 / count==depth
//   overflow    sticky, set when a push is dropped
//   drop_count  saturating count of dropped pushes
module golden_nonce_queue #(
  parameter int DEPTH_LOG2    = 3,
  parameter int WIDTH         = 32,
  parameter int BUSY_WAIT_MAX = 15
) (
  input  logic                  hash_clk,
  input  logic                  reset_in,
  input  logic                  flush,
  golden_nonce_queue_if.slave   nq,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WCW   = $clog2(BUSY_WAIT_MAX + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic                  empty_reg, full_reg;
  logic                  overflow_reg;
  logic [7:0]            drop_count_reg;
  logic [WIDTH-1:0]      tx_word_reg;
  logic                  tx_send_reg;
  logic [WCW-1:0]        wait_cnt_reg;
  state_t                state_reg;

  logic pop, accept, drop;

  // The head entry is only released once the UART has finished with it, so
  // a pop frees a slot in the same cycle and lets a push into a full queue.
  assign pop    = (state_reg == WAIT_LO) && !nq.tx_busy;
  assign accept = nq.push && (!full_reg || pop);
  assign drop   = nq.push && full_reg && !pop;

  always_comb begin
    count_next = count_reg;
    if (accept && !pop)
      count_next = count_reg + 1'b1;
    else if (pop && !accept)
      count_next = count_reg - 1'b1;
  end

  // Storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge hash_clk) begin
    if (accept && !flush)
      mem[wr_ptr_reg] <= nq.push_word;
  end

  always_ff @(posedge hash_clk or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      empty_reg      <= 1'b1;
      full_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= 8'd0;
    end else if (flush) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      empty_reg      <= 1'b1;
      full_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= 8'd0;
    end else begin
      if (accept)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      empty_reg <= (count_next == '0);
      full_reg  <= (count_next == (DEPTH_LOG2+1)'(DEPTH));
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != 8'hFF)
          drop_count_reg <= drop_count_reg + 8'd1;
      end
    end
  end

  // Handshake FSM. tx_word is loaded only on IDLE->SEND so it stays stable
  // across retries until the pop.
  always_ff @(posedge hash_clk or negedge reset_in) begin
    if (!reset_in) begin
      state_reg    <= IDLE;
      tx_word_reg  <= '0;
      tx_send_reg  <= 1'b0;
      wait_cnt_reg <= '0;
    end else if (flush) begin
      state_reg    <= IDLE;
      tx_word_reg  <= '0;
      tx_send_reg  <= 1'b0;
      wait_cnt_reg <= '0;
    end else begin
      tx_send_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Never start while the UART is busy (also covers an external
          // sender holding the line).
          if (!empty_reg && !nq.tx_busy) begin
            tx_word_reg <= mem[rd_ptr_reg];
            tx_send_reg <= 1'b1;
            state_reg   <= SEND;
          end
        end
        SEND: begin
          wait_cnt_reg <= '0;
          state_reg    <= WAIT_HI;
        end
        WAIT_HI: begin
          if (nq.tx_busy) begin
            state_reg <= WAIT_LO;
          end else if (wait_cnt_reg == WCW'(BUSY_WAIT_MAX)) begin
            // UART never acknowledged: re-issue the same word.
            tx_send_reg <= 1'b1;
            state_reg   <= SEND;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!nq.tx_busy)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign nq.tx_word  = tx_word_reg;
  assign nq.tx_send  = tx_send_reg;
  assign count       = count_reg;
  assign empty       = empty_reg;
  assign full        = full_reg;
  assign overflow    = overflow_reg;
  assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_golden_nonce_queue.sv
module tb_golden_nonce_queue;
  localparam int DL  = 3;
  localparam int W   = 32;
  localparam int BWM = 15;

  logic          hash_clk = 1'b0;
  logic          reset_in;
  logic          flush;
  logic [DL:0]   count;
  logic          empty, full, overflow;
  logic [7:0]    drop_count;

  golden_nonce_queue_if #(.WIDTH(W)) nq();

  golden_nonce_queue #(.DEPTH_LOG2(DL), .WIDTH(W), .BUSY_WAIT_MAX(BWM)) dut (
    .hash_clk   (hash_clk),
    .reset_in   (reset_in),
    .flush      (flush),
    .nq         (nq),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 hash_clk = ~hash_clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cycle = 0;
  int         sends = 0;
  int         last_send_cyc = -1;
  logic [W-1:0] last_sent_word = '0;
  int         send_cyc[$];
  logic [W-1:0] sb[$];
  bit         uart_en = 1'b1;
  int         busy_len = 10;
  bit         stall = 1'b0;
  bit         busy_model = 1'b0;
  bit         rise_pending = 1'b0;
  int         hold_left = 0;
  int         max_count = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: UART model (busy one cycle after send, held busy_len cycles)
  // and the scoreboard monitor on tx_send.
  task automatic tick();
    @(posedge hash_clk);
    #1;
    cycle++;
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) busy_model = 1'b0;
    end
    if (rise_pending) begin
      rise_pending = 1'b0;
      busy_model   = 1'b1;
      hold_left    = busy_len;
    end
    if (nq.tx_send) begin
      sends++;
      last_send_cyc  = cycle;
      last_sent_word = nq.tx_word;
      send_cyc.push_back(cycle);
      $display("send #%0d word 0x%08h cycle %0d", sends, nq.tx_word, cycle);
      if (sb.size() == 0)
        chk("spurious_send", nq.tx_send, 0);
      else if (uart_en)
        chk("tx_word", nq.tx_word, sb.pop_front());
      else
        chk("retry_word", nq.tx_word, sb[0]);
      if (uart_en) rise_pending = 1'b1;
    end
    nq.tx_busy = stall | busy_model;
    if (int'(count) > max_count) max_count = int'(count);
  endtask

  task automatic set_stall(input bit s);
    stall = s;
    nq.tx_busy = stall | busy_model;
  endtask

  task automatic uart_reset();
    busy_model   = 1'b0;
    hold_left    = 0;
    rise_pending = 1'b0;
    nq.tx_busy   = stall;
  endtask

  task automatic drive_push(input logic [W-1:0] word, input bit accepted);
    nq.push      = 1'b1;
    nq.push_word = word;
    if (accepted) sb.push_back(word);
    tick();
    nq.push = 1'b0;
  endtask

  task automatic wait_busy(input bit val, input string tag);
    for (int i = 0; i < 100; i++) begin
      if (nq.tx_busy == val) break;
      tick();
    end
    chk(tag, nq.tx_busy, val);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 600; i++) begin
      if (sb.size() == 0 && count == 0 && !nq.tx_busy && !rise_pending) break;
      tick();
    end
    for (int i = 0; i < 4; i++) tick();
    chk({tag, "_count"}, count, 0);
    chk({tag, "_sb_left"}, sb.size(), 0);
  endtask

  // Three entries queued, first one in WAIT_LO with the UART busy.
  task automatic setup3(input logic [W-1:0] base);
    set_stall(1'b1);
    for (int i = 0; i < 3; i++) drive_push(base + W'(i), 1'b1);
    set_stall(1'b0);
    wait_busy(1'b1, "setup3_busy");
    tick();
    tick();
    chk("setup3_count", count, 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, pc;
    reset_in     = 1'b0;
    flush        = 1'b0;
    nq.push      = 1'b0;
    nq.push_word = '0;
    nq.tx_busy   = 1'b0;
    tick();
    tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_tx_word", nq.tx_word, 0);
    chk("rst_tx_send", nq.tx_send, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_count, 0);
    #4 reset_in = 1'b1;
    tick();

    // Single nonce, latency and count lifetime
    s0 = sends;
    pc = cycle;
    drive_push(32'h1D3F00A5, 1'b1);
    chk("t1_count_push", count, 1);
    chk("t1_empty_push", empty, 0);
    tick();
    chk("t1_send_seen", sends - s0, 1);
    chk("t1_latency", last_send_cyc - pc, 2);
    tick();
    tick();
    tick();
    chk("t1_count_busy", count, 1);
    drain("t1");
    chk("t1_send_total", sends - s0, 1);
    chk("t1_empty_end", empty, 1);

    // Burst of five
    s0 = sends;
    max_count = 0;
    for (int i = 1; i <= 5; i++) drive_push(W'(i), 1'b1);
    drain("t2");
    chk("t2_sends", sends - s0, 5);
    chk("t2_peak", max_count, 5);
    chk("t2_overflow", overflow, 0);

    // Overflow while the UART is stalled
    s0 = sends;
    set_stall(1'b1);
    for (int i = 1; i <= 10; i++) begin
      drive_push(32'h03000000 + W'(i), i <= 8);
      if (i == 7) chk("t3_full_at7", full, 0);
      if (i == 8) chk("t3_full_at8", full, 1);
    end
    chk("t3_count", count, 8);
    chk("t3_drop", drop_count, 2);
    chk("t3_overflow", overflow, 1);
    chk("t3_no_send_stalled", sends - s0, 0);
    set_stall(1'b0);
    drain("t3");
    chk("t3_sends", sends - s0, 8);
    chk("t3_overflow_sticky", overflow, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_overflow", overflow, 0);
    chk("flush_drop", drop_count, 0);

    // Full queue, push coincides with the pop
    s0 = sends;
    set_stall(1'b1);
    for (int i = 0; i < 8; i++) drive_push(32'h04000000 + W'(i), 1'b1);
    set_stall(1'b0);
    wait_busy(1'b1, "t4_busy_hi");
    wait_busy(1'b0, "t4_busy_lo");
    chk("t4_full_before", full, 1);
    drive_push(32'hCAFEBABE, 1'b1);
    chk("t4_count", count, 8);
    chk("t4_full", full, 1);
    chk("t4_drop", drop_count, 0);
    drain("t4");
    chk("t4_sends", sends - s0, 9);
    chk("t4_last_word", last_sent_word, 32'hCAFEBABE);
    chk("t4_overflow", overflow, 0);

    // UART never acknowledges: retries with the same word, no pop
    uart_en = 1'b0;
    send_cyc.delete();
    s0 = sends;
    drive_push(32'h5A5A0001, 1'b1);
    for (int i = 0; i < 100; i++) begin
      if (sends - s0 >= 3) break;
      tick();
    end
    chk("t5_sends", sends - s0, 3);
    if (send_cyc.size() >= 3) begin
      chk("t5_period1", send_cyc[1] - send_cyc[0], BWM + 2);
      chk("t5_period2", send_cyc[2] - send_cyc[1], BWM + 2);
    end
    chk("t5_count", count, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    uart_en = 1'b1;
    chk("t5_flush_count", count, 0);
    chk("t5_flush_word", nq.tx_word, 0);

    // Async reset mid-transfer
    setup3(32'h06000000);
    #3 reset_in = 1'b0;
    #1;
    chk("t6_rst_count", count, 0);
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_full", full, 0);
    chk("t6_rst_word", nq.tx_word, 0);
    chk("t6_rst_send", nq.tx_send, 0);
    uart_reset();
    sb.delete();
    #1 reset_in = 1'b1;
    s0 = sends;
    for (int i = 0; i < 6; i++) tick();
    chk("t6_no_send", sends - s0, 0);
    chk("t6_count_after", count, 0);

    // Flush mid-transfer with a simultaneous push
    setup3(32'h07000000);
    flush        = 1'b1;
    nq.push      = 1'b1;
    nq.push_word = 32'hDEADBEEF;
    tick();
    flush   = 1'b0;
    nq.push = 1'b0;
    chk("t7_count", count, 0);
    chk("t7_empty", empty, 1);
    chk("t7_word", nq.tx_word, 0);
    chk("t7_send", nq.tx_send, 0);
    uart_reset();
    sb.delete();
    s0 = sends;
    for (int i = 0; i < 6; i++) tick();
    chk("t7_push_ignored", count, 0);
    chk("t7_no_send", sends - s0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
